simple_acc_reducer: RTL and testbench



---
 rtl/simple_acc_reducer.sv | 92 +++++++++
 tb/tb_simple_acc_reducer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_acc_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : simple_acc_reducer
//  Description : Lane-wise accumulator that sums a programmable number of
//                consecutive multiplier result vectors and presents the total
//                on a valid-ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module simple_acc_reducer #(
    parameter int SpatPar   = 4,
    parameter int DataWidth = 64,
    parameter int CntWidth  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [CntWidth-1:0]            acc_len_i,
    input  logic [SpatPar*DataWidth-1:0]   data_i,
    input  logic                           data_valid_i,
    output logic                           data_ready_o,
    output logic [SpatPar*DataWidth-1:0]   acc_o,
    output logic                           acc_valid_o,
    input  logic                           acc_ready_i,
    output logic                           busy_o
);

    localparam logic [0:0] c_ST_ACCUM  = 1'b0;
    localparam logic [0:0] c_ST_OUTPUT = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [CntWidth-1:0]  r_cnt;
    logic [CntWidth-1:0]  r_len;
    logic [CntWidth-1:0]  w_len_eff;
    logic [CntWidth-1:0]  w_cur_len;
    logic [DataWidth-1:0] r_acc [SpatPar];
    logic                 w_beat;
    logic                 w_first;
    logic                 w_last;
    logic                 w_out_hs;

    assign acc_valid_o  = (r_state == c_ST_OUTPUT);
    // Ready only waits on the consumer while a result is being held.
    assign data_ready_o = (r_state == c_ST_ACCUM) ? 1'b1 : acc_ready_i;
    assign busy_o       = (r_cnt != '0);

    assign w_beat    = data_valid_i && data_ready_o;
    assign w_out_hs  = acc_valid_o && acc_ready_i;
    assign w_first   = (r_cnt == '0);
    assign w_len_eff = (acc_len_i == '0) ? CntWidth'(1) : acc_len_i;
    // The group length is the live input on the first beat, the latched one after.
    assign w_cur_len = w_first ? w_len_eff : r_len;
    assign w_last    = (r_cnt == (w_cur_len - CntWidth'(1)));

    always_comb begin
        w_state_nxt = r_state;
        if (w_beat && w_last) begin
            w_state_nxt = c_ST_OUTPUT;
        end else if (w_out_hs) begin
            w_state_nxt = c_ST_ACCUM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_ST_ACCUM;
            r_cnt   <= '0;
            r_len   <= CntWidth'(1);
        end else begin
            r_state <= w_state_nxt;
            if (w_beat) begin
                r_cnt <= w_last ? '0 : (r_cnt + CntWidth'(1));
                if (w_first) begin
                    r_len <= w_len_eff;
                end
            end
        end
    end

    for (genvar i = 0; i < SpatPar; i++) begin : g_lane
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_acc[i] <= '0;
            end else if (w_beat) begin
                r_acc[i] <= w_first ? data_i[i*DataWidth +: DataWidth]
                                    : r_acc[i] + data_i[i*DataWidth +: DataWidth];
            end
        end
        assign acc_o[i*DataWidth +: DataWidth] = r_acc[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_simple_acc_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simple_acc_reducer
//  Description : Self-checking bench for simple_acc_reducer: directed
//                scenarios plus randomized traffic against a group-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_acc_reducer;

    localparam int c_LANES = 4;
    localparam int c_DW    = 64;
    localparam int c_CW    = 8;

    logic                     clk;
    logic                     rst_n;
    logic [c_CW-1:0]          acc_len;
    logic [c_LANES*c_DW-1:0]  data;
    logic                     data_valid;
    logic                     data_ready;
    logic [c_LANES*c_DW-1:0]  acc;
    logic                     acc_valid;
    logic                     acc_ready;
    logic                     busy;

    simple_acc_reducer #(
        .SpatPar   (c_LANES),
        .DataWidth (c_DW),
        .CntWidth  (c_CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .acc_len_i    (acc_len),
        .data_i       (data),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .acc_o        (acc),
        .acc_valid_o  (acc_valid),
        .acc_ready_i  (acc_ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit en     = 1'b0;

    // Group-level model: running sum of the open group plus a held result.
    int          m_cnt;
    int          m_len;
    logic [63:0] m_sum [c_LANES];
    bit          m_pend;
    logic [63:0] m_out [c_LANES];

    function automatic logic [c_LANES*c_DW-1:0] pack_out();
        logic [c_LANES*c_DW-1:0] v;
        for (int i = 0; i < c_LANES; i++) v[i*c_DW +: c_DW] = m_out[i];
        return v;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_len  = 1;
        m_pend = 1'b0;
        for (int i = 0; i < c_LANES; i++) begin
            m_sum[i] = '0;
            m_out[i] = '0;
        end
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare then advance the model at each negedge; inputs are stable here.
    always @(negedge clk) begin
        if (en) begin
            bit exp_ready, beat, hs;
            exp_ready = !m_pend || acc_ready;
            check("valid", 256'(acc_valid), 256'(m_pend));
            check("ready", 256'(data_ready), 256'(exp_ready));
            check("busy",  256'(busy), 256'(m_cnt != 0));
            if (m_pend) check("acc", 256'(acc), 256'(pack_out()));
            beat = data_valid && exp_ready;
            hs   = m_pend && acc_ready;
            if (!rst_n) begin
                model_reset();
            end else begin
                if (hs) m_pend = 1'b0;
                if (beat) begin
                    if (m_cnt == 0) begin
                        m_len = (acc_len == 0) ? 1 : int'(acc_len);
                        for (int i = 0; i < c_LANES; i++) m_sum[i] = data[i*c_DW +: c_DW];
                    end else begin
                        for (int i = 0; i < c_LANES; i++) m_sum[i] = m_sum[i] + data[i*c_DW +: c_DW];
                    end
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_cnt  = 0;
                        m_pend = 1'b1;
                        for (int i = 0; i < c_LANES; i++) m_out[i] = m_sum[i];
                    end
                end
            end
        end
    end

    function automatic logic [c_LANES*c_DW-1:0] mk(input logic [63:0] a, input logic [63:0] b,
                                                  input logic [63:0] c, input logic [63:0] d);
        return {d, c, b, a};
    endfunction

    task automatic cyc(input bit v, input logic [c_LANES*c_DW-1:0] d,
                       input logic [c_CW-1:0] len, input bit rdy);
        @(posedge clk);
        #1;
        data_valid = v;
        data       = d;
        acc_len    = len;
        acc_ready  = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 8'd1, 1'b1);
    endtask

    initial begin
        logic [c_LANES*c_DW-1:0] held;
        model_reset();
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data       = '0;
        acc_len    = 8'd1;
        acc_ready  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1;
        @(negedge clk);
        check("lit_reset_ready", 256'(data_ready), 256'(1));
        check("lit_reset_valid", 256'(acc_valid), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // L=3 dot-product group
        cyc(1'b1, mk(1, 2, 3, 4), 8'd3, 1'b1);
        cyc(1'b1, mk(10, 20, 30, 40), 8'd3, 1'b1);
        @(negedge clk);
        check("lit_busy_mid", 256'(busy), 256'(1));
        cyc(1'b1, mk(100, 200, 300, 400), 8'd3, 1'b1);
        cyc(1'b0, '0, 8'd3, 1'b1);
        @(negedge clk);
        check("lit_sum3_valid", 256'(acc_valid), 256'(1));
        check("lit_sum3", 256'(acc), 256'(mk(111, 222, 333, 444)));
        idle(2);

        // L=1 full throughput
        cyc(1'b1, mk(5, 0, 0, 0), 8'd1, 1'b1);
        cyc(1'b1, mk(6, 0, 0, 0), 8'd1, 1'b1);
        @(negedge clk);
        check("lit_l1_a", 256'(acc[63:0]), 256'(5));
        cyc(1'b1, mk(7, 0, 0, 0), 8'd1, 1'b1);
        @(negedge clk);
        check("lit_l1_b", 256'(acc[63:0]), 256'(6));
        check("lit_l1_ready", 256'(data_ready), 256'(1));
        cyc(1'b0, '0, 8'd1, 1'b1);
        @(negedge clk);
        check("lit_l1_c", 256'(acc[63:0]), 256'(7));
        idle(2);

        // Per-lane wrap without inter-lane carry
        cyc(1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0), 8'd2, 1'b1);
        cyc(1'b1, mk(2, 0, 0, 0), 8'd2, 1'b1);
        cyc(1'b0, '0, 8'd2, 1'b1);
        @(negedge clk);
        check("lit_wrap", 256'(acc), 256'(mk(1, 0, 0, 0)));
        idle(2);

        // Backpressure with a waiting input beat
        cyc(1'b1, mk(3, 3, 3, 3), 8'd2, 1'b0);
        cyc(1'b1, mk(4, 4, 4, 4), 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(50, 60, 70, 80), 8'd2, 1'b0);
            @(negedge clk);
            check("lit_bp_ready", 256'(data_ready), 256'(0));
            check("lit_bp_hold", 256'(acc), 256'(mk(7, 7, 7, 7)));
        end
        cyc(1'b1, mk(50, 60, 70, 80), 8'd2, 1'b1);
        cyc(1'b1, mk(1, 1, 1, 1), 8'd2, 1'b1);
        cyc(1'b0, '0, 8'd2, 1'b1);
        @(negedge clk);
        check("lit_bp_next", 256'(acc), 256'(mk(51, 61, 71, 81)));
        idle(2);

        // Zero length acts as one; length change mid-group ignored
        cyc(1'b1, mk(9, 8, 7, 6), 8'd0, 1'b1);
        cyc(1'b0, '0, 8'd0, 1'b1);
        @(negedge clk);
        check("lit_len0", 256'(acc), 256'(mk(9, 8, 7, 6)));
        idle(1);
        cyc(1'b1, mk(1, 0, 0, 0), 8'd4, 1'b1);
        cyc(1'b1, mk(1, 0, 0, 0), 8'd2, 1'b1);
        cyc(1'b0, '0, 8'd2, 1'b1);
        @(negedge clk);
        check("lit_len_chg_nov", 256'(acc_valid), 256'(0));
        cyc(1'b1, mk(1, 0, 0, 0), 8'd2, 1'b1);
        cyc(1'b1, mk(1, 0, 0, 0), 8'd2, 1'b1);
        cyc(1'b0, '0, 8'd2, 1'b1);
        @(negedge clk);
        check("lit_len_chg", 256'(acc), 256'(mk(4, 0, 0, 0)));
        idle(2);

        // Reset mid-group
        cyc(1'b1, mk(20, 20, 20, 20), 8'd3, 1'b1);
        cyc(1'b1, mk(20, 20, 20, 20), 8'd3, 1'b1);
        cyc(1'b0, '0, 8'd3, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, '0, 8'd3, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_rst_valid", 256'(acc_valid), 256'(0));
        check("lit_rst_busy", 256'(busy), 256'(0));
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(1, 1, 1, 1), 8'd3, 1'b1);
        cyc(1'b0, '0, 8'd3, 1'b1);
        @(negedge clk);
        check("lit_rst_sum", 256'(acc), 256'(mk(3, 3, 3, 3)));
        idle(2);

        // Randomized traffic; the compare process does the checking
        for (int n = 0; n < 3000; n++) begin
            held = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) held = mk($urandom_range(0, 3), $urandom_range(0, 3), 0, 1);
            cyc($urandom_range(0, 3) != 0, held, 8'($urandom_range(0, 4)), $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 400) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
        end
        rst_n = 1'b1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
